// File: rtl/score_select.sv
// Collects one round of fp32 task scores and holds the highest-scoring task on a
// valid/ready output until the scheduler takes it. NaN loses to any number; ties keep the first arrival.
module score_select #(
   parameter  int SCORE_BITWIDTH = 32,
   parameter  int NUM_TASKS      = 8,
   localparam int ID_WIDTH       = $clog2(NUM_TASKS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [ID_WIDTH:0]         num_cand,
   input  logic                      score_vld,
   input  logic [SCORE_BITWIDTH-1:0] score_dat,
   input  logic [ID_WIDTH-1:0]       score_id,
   output logic                      score_rdy,
   output logic                      sel_vld,
   output logic [ID_WIDTH-1:0]       sel_id,
   output logic [SCORE_BITWIDTH-1:0] sel_score,
   output logic                      sel_nan,
   input  logic                      sel_rdy,
   output logic                      busy,
   output logic                      err
);

   // state     | meaning
   // S_IDLE    | waiting for a legal start
   // S_COLLECT | accepting score beats, tracking the best so far
   // S_OUTPUT  | winner presented, waiting for sel_rdy
   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_OUTPUT} state_t;

   localparam logic [ID_WIDTH:0] C_MAX_CAND = (ID_WIDTH+1)'(NUM_TASKS);

   state_t                    r_state;
   state_t                    w_next;
   logic [ID_WIDTH:0]         r_count;
   logic [ID_WIDTH:0]         r_num;
   logic [SCORE_BITWIDTH-1:0] r_best_score;
   logic [ID_WIDTH-1:0]       r_best_id;
   logic                      r_loaded;
   logic                      r_err;

   logic                      w_id_ok;
   logic                      w_start_ok;
   logic                      w_last;
   logic                      w_beat_nan;
   logic                      w_best_nan;
   logic                      w_replace;
   logic [ID_WIDTH:0]         w_count_inc;

   function automatic logic f_is_nan(input logic [SCORE_BITWIDTH-1:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   // Order-preserving unsigned key; -0 folds onto +0 so the two tie.
   function automatic logic [SCORE_BITWIDTH-1:0] f_key(input logic [SCORE_BITWIDTH-1:0] x);
      logic [SCORE_BITWIDTH-1:0] c;
      c = (x == {1'b1, {(SCORE_BITWIDTH-1){1'b0}}}) ? '0 : x;
      return c[SCORE_BITWIDTH-1] ? ~c : (c ^ {1'b1, {(SCORE_BITWIDTH-1){1'b0}}});
   endfunction

   generate
      if (NUM_TASKS == (1 << ID_WIDTH)) begin : g_id_full
         assign w_id_ok = 1'b1;
      end else begin : g_id_check
         assign w_id_ok = ({1'b0, score_id} < C_MAX_CAND);
      end
   endgenerate

   assign w_start_ok  = start && (num_cand != '0) && (num_cand <= C_MAX_CAND);
   assign w_count_inc = r_count + 1'b1;
   assign w_last      = (w_count_inc == r_num);
   assign w_beat_nan  = f_is_nan(score_dat);
   assign w_best_nan  = f_is_nan(r_best_score);
   assign w_replace   = !r_loaded
                     || (w_best_nan && !w_beat_nan)
                     || (!w_best_nan && !w_beat_nan && (f_key(score_dat) > f_key(r_best_score)));

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_count      <= '0;
         r_num        <= '0;
         r_best_score <= '0;
         r_best_id    <= '0;
         r_loaded     <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state <= w_next;
         r_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start_ok) begin
                  r_num    <= num_cand;
                  r_count  <= '0;
                  r_loaded <= 1'b0;
               end else if (start) begin
                  r_err <= 1'b1;
               end
            end
            S_COLLECT: begin
               if (score_vld) begin
                  r_count <= w_count_inc;
                  if (!w_id_ok) begin
                     r_err <= 1'b1;
                  end else if (w_replace) begin
                     r_best_score <= score_dat;
                     r_best_id    <= score_id;
                     r_loaded     <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_start_ok) w_next = S_COLLECT;
         S_COLLECT: if (score_vld && w_last) w_next = S_OUTPUT;
         S_OUTPUT:  if (sel_rdy) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      score_rdy = (r_state == S_COLLECT);
      busy      = (r_state != S_IDLE);
      err       = r_err;
      sel_vld   = 1'b0;
      sel_id    = '0;
      sel_score = '0;
      sel_nan   = 1'b0;
      if (r_state == S_OUTPUT) begin
         sel_vld   = 1'b1;
         sel_id    = r_best_id;
         sel_score = r_best_score;
         sel_nan   = w_best_nan;
      end
   end

endmodule
